mempool_boot_ctrl: RTL and testbench

Boot and completion sequencer for the MemPool cluster. It latches a boot address and drives the cluster's `fetch_enable_i` per core, enabling cores in a staggered order to spread instruction-fetch and I-cache refill load. It monitors per-core busy flags to detect end of computation. It sits between the SoC control registers (start pulse, boot address) and `mempool_cluster`, replacing the constant fetch enable and boot address ties.

---
 rtl/mempool_pkg.sv | 20 ++
 rtl/mempool_idle_monitor.sv | 48 ++++
 rtl/mempool_boot_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mempool_boot_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mempool_pkg.sv
// Shared types and default timing constants for the MemPool boot/completion sequencer.
package mempool_pkg;

  localparam int unsigned DefAddrWidth     = 32;
  localparam int unsigned DefStaggerCycles = 4;
  localparam int unsigned DefIdleCycles    = 8;
  localparam int unsigned DefTimeoutCycles = 2**20;

  typedef logic [DefAddrWidth-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    STAGGER,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } boot_state_e;

endpackage

// File: rtl/mempool_idle_monitor.sv
// Tracks which enabled cores have ever been seen busy and counts consecutive
// all-idle cycles once every core has been seen busy at least once.
module mempool_idle_monitor
  import mempool_pkg::*;
#(
  parameter int unsigned NumCores   = 16,
  parameter int unsigned IdleCycles = DefIdleCycles
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumCores-1:0] busy_i,
  input  logic [NumCores-1:0] enable_i,
  input  logic                clear_i,
  output logic                all_idle_o,
  output logic                idle_done_o
);

  localparam int unsigned     CntW    = $clog2(IdleCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(IdleCycles);

  logic [NumCores-1:0] seen_q, seen_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // A never-seen-busy core blocks completion, so cores still in reset are not mistaken for idle.
  always_comb begin
    seen_d      = clear_i ? '0 : (seen_q | (busy_i & enable_i));
    all_idle_o  = (|enable_i) && (&seen_q) && !(|busy_i);
    idle_done_o = all_idle_o && (cnt_q == CntLast);
    cnt_d       = cnt_q;
    if (clear_i || !all_idle_o) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seen_q <= '0;
      cnt_q  <= '0;
    end else begin
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mempool_boot_ctrl.sv
// Boot sequencer: latches the boot address, staggers per-core fetch enables and
// detects completion. MEMPOOL_BOOT_CTRL_WATCHDOG_EN builds the watchdog/TIMEOUT path.
module mempool_boot_ctrl
  import mempool_pkg::*;
#(
  parameter int unsigned NumCores      = 16,
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter int unsigned StaggerCycles = DefStaggerCycles,
  parameter int unsigned IdleCycles    = DefIdleCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] boot_addr_i,
  input  logic [NumCores-1:0]  busy_i,
  output logic [NumCores-1:0]  fetch_enable_o,
  output logic [AddrWidth-1:0] boot_addr_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 timeout_o
);

  localparam int unsigned     StgW      = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
  localparam int unsigned     IdxW      = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam logic [StgW-1:0] StgReload = StgW'(StaggerCycles - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumCores - 1);

  boot_state_e          state_q, state_d;
  logic [NumCores-1:0]  fen_q, fen_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [StgW-1:0]      stg_q, stg_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 accept, all_idle, idle_done;

`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
  localparam int unsigned    WdW    = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
  localparam logic [WdW-1:0] WdMax  = WdW'(TimeoutCycles);
  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  mempool_idle_monitor #(
    .NumCores  (NumCores),
    .IdleCycles(IdleCycles)
  ) i_idle_monitor (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .busy_i     (busy_i),
    .enable_i   (fen_q),
    .clear_i    (accept),
    .all_idle_o (all_idle),
    .idle_done_o(idle_done)
  );

  always_comb begin
    state_d = state_q;
    fen_d   = fen_q;
    addr_d  = addr_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start_i) begin
          accept  = 1'b1;
          addr_d  = boot_addr_i;
          stg_d   = '0;
          idx_d   = '0;
          state_d = STAGGER;
        end
      end
      STAGGER: begin
        if (stg_q == '0) begin
          fen_d = fen_q | (NumCores'(1) << idx_q);
          if (idx_q == IdxLast) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
            stg_d = StgReload;
          end
        end else begin
          stg_d = stg_q - 1'b1;
        end
      end
      RUN: begin
        if (idle_done) begin
          state_d = DONE;
        end else if (all_idle) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!all_idle) begin
          state_d = RUN;
        end else if (idle_done) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
    wd_d = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if ((state_q inside {STAGGER, RUN, DRAIN}) && (wd_q != WdMax)) begin
      wd_d = wd_q + 1'b1;
    end
    // Completion takes priority over a watchdog expiry in the same cycle.
    if ((state_q inside {STAGGER, RUN, DRAIN}) && (wd_q == WdLast) && (state_d != DONE)) begin
      state_d = TIMEOUT;
    end
    timeout_d = (state_d == TIMEOUT);
`endif

    if (state_d inside {DONE, TIMEOUT}) begin
      fen_d = '0;
    end
    done_d    = (state_d == DONE);
    running_d = |fen_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fen_q     <= '0;
      addr_q    <= '0;
      stg_q     <= '0;
      idx_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fen_q     <= fen_d;
      addr_q    <= addr_d;
      stg_q     <= stg_d;
      idx_q     <= idx_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb timeout_o = timeout_q;
`else
  logic unused_timeout_cycles;
  always_comb unused_timeout_cycles = ^TimeoutCycles;
  always_comb timeout_o = 1'b0;
`endif

  always_comb begin
    fetch_enable_o = fen_q;
    boot_addr_o    = addr_q;
    running_o      = running_q;
    done_o         = done_q;
  end

endmodule

// File: tb/tb_mempool_boot_ctrl.sv
// Directed bench for mempool_boot_ctrl with a cycle-age based reference model.
module tb_mempool_boot_ctrl;

  localparam int N  = 16;
  localparam int S  = 4;
  localparam int IC = 8;
  localparam int TC = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   addr = '0;
  logic [N-1:0]  busy = '0;
  logic [N-1:0]  fen;
  logic [31:0]   addr_o;
  logic          running, done, timeout;

  logic          start1 = 1'b0;
  logic [0:0]    busy1 = '0;
  logic [0:0]    fen1;
  logic [31:0]   addr1_o;
  logic          running1, done1, timeout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mempool_boot_ctrl #(
    .NumCores(N), .AddrWidth(32), .StaggerCycles(S), .IdleCycles(IC), .TimeoutCycles(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .boot_addr_i(addr), .busy_i(busy),
    .fetch_enable_o(fen), .boot_addr_o(addr_o), .running_o(running), .done_o(done),
    .timeout_o(timeout)
  );

  mempool_boot_ctrl #(
    .NumCores(1), .AddrWidth(32), .StaggerCycles(1), .IdleCycles(IC), .TimeoutCycles(TC)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .boot_addr_i(32'h0000_1000), .busy_i(busy1),
    .fetch_enable_o(fen1), .boot_addr_o(addr1_o), .running_o(running1), .done_o(done1),
    .timeout_o(timeout1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the age (edges since start acceptance).
  logic         m_active = 1'b0;
  logic         m_done   = 1'b0;
  logic         m_to     = 1'b0;
  int           m_age    = 0;
  int           m_idle   = 0;
  logic [N-1:0] m_seen   = '0;
  logic [31:0]  m_addr   = '0;

  function automatic logic [N-1:0] m_fen(input logic act, input int age);
    m_fen = '0;
    for (int k = 0; k < N; k++) if (act && age >= 1 + k * S) m_fen[k] = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [N-1:0] f;
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_to = 1'b0;
      m_age = 0; m_idle = 0; m_seen = '0; m_addr = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_done = 1'b0; m_to = 1'b0;
        m_age = 0; m_idle = 0; m_seen = '0; m_addr = addr;
      end
    end else begin
      f      = m_fen(1'b1, m_age);
      m_seen = m_seen | (busy & f);
      if (m_seen == '1 && busy == '0) m_idle++; else m_idle = 0;
      m_age++;
      if (m_idle >= IC) begin
        m_active = 1'b0; m_done = 1'b1;
      end
`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
      else if (m_age >= TC) begin
        m_active = 1'b0; m_to = 1'b1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("fetch_enable", 64'(fen), 64'(m_fen(m_active, m_age)));
      check("running", 64'(running), 64'(m_active && m_age >= 1));
      check("done", 64'(done), 64'(m_done));
      check("timeout", 64'(timeout), 64'(m_to));
      check("boot_addr", 64'(addr_o), 64'(m_addr));
    end
  end

  function automatic logic [N-1:0] pat(input int n);
    pat = '0;
    for (int k = 0; k < N; k++)
      if (n >= 1 + k * S + 3 && n < 1 + k * S + 23) pat[k] = 1'b1;
  endfunction

  // Called at a negedge in an accepting state; returns after the acceptance edge.
  task automatic accept(input logic [31:0] a);
    start = 1'b1;
    addr  = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fen", 64'(fen), 64'h0);
    check("rst_running", 64'(running), 64'h0);
    check("rst_addr", 64'(addr_o), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Stagger with no busy cores; late start pulse ignored
    accept(32'h8000_0000);
    for (int n = 0; n <= 70; n++) begin
      busy = '0;
      if (n == 0) begin
        check("s1_addr_t0", 64'(addr_o), 64'h8000_0000);
        check("s1_fen_t0", 64'(fen), 64'h0);
      end
      if (n == 1)  check("s1_fen_t1", 64'(fen), 64'h0001);
      if (n == 4)  check("s1_fen_t4", 64'(fen), 64'h0001);
      if (n == 5)  check("s1_fen_t5", 64'(fen), 64'h0003);
      if (n == 60) check("s1_fen_t60", 64'(fen), 64'h7fff);
      if (n == 61) check("s1_fen_t61", 64'(fen), 64'hffff);
      if (n == 65) begin start = 1'b1; addr = 32'h0000_1234; end
      if (n == 66) begin start = 1'b0; addr = 32'h8000_0000; end
      if (n == 68) begin
        check("s1_ign_addr", 64'(addr_o), 64'h8000_0000);
        check("s1_ign_fen", 64'(fen), 64'hffff);
      end
      if (n == 70) check("s1_no_done", 64'(done), 64'h0);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted mid-STAGGER
    accept(32'h0000_0040);
    for (int n = 0; n <= 10; n++) begin
      if (n == 10) check("s5_fen_pre", 64'(fen), 64'h0007);
      else @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("s5_rst_fen", 64'(fen), 64'h0);
    check("s5_rst_running", 64'(running), 64'h0);
    check("s5_rst_addr", 64'(addr_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s5_idle_fen", 64'(fen), 64'h0);

    // Full run to completion; start in the DONE-transition cycle ignored
    accept(32'h8000_0100);
    for (int n = 0; n <= 95; n++) begin
      busy = pat(n);
      if (n == 91) begin
        check("s2_done_early", 64'(done), 64'h0);
        start = 1'b1; addr = 32'hdead_0000;
      end
      if (n == 92) begin
        start = 1'b0; addr = 32'h8000_0100;
        check("s2_done", 64'(done), 64'h1);
        check("s2_fen_clr", 64'(fen), 64'h0);
        check("s2_running", 64'(running), 64'h0);
      end
      if (n == 94) begin
        check("s2_done_hold", 64'(done), 64'h1);
        check("s2_addr_hold", 64'(addr_o), 64'h8000_0100);
      end
      @(negedge clk);
    end

    // Core 5 re-raises busy for one cycle during DRAIN
    accept(32'h8000_0200);
    for (int n = 0; n <= 100; n++) begin
      busy = pat(n);
      if (n == 88) busy[5] = 1'b1;
      if (n == 90) check("s3_back_run", 64'(running), 64'h1);
      if (n == 96) check("s3_done_early", 64'(done), 64'h0);
      if (n == 97) begin
        check("s3_done", 64'(done), 64'h1);
        check("s3_fen_clr", 64'(fen), 64'h0);
      end
      @(negedge clk);
    end

    // Core 0 never goes idle
    accept(32'h8000_0300);
    for (int n = 0; n <= 103; n++) begin
      busy = 16'h0001;
`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
      if (n == 99) check("s4_to_early", 64'(timeout), 64'h0);
      if (n == 100) begin
        check("s4_timeout", 64'(timeout), 64'h1);
        check("s4_fen_clr", 64'(fen), 64'h0);
        check("s4_no_done", 64'(done), 64'h0);
        check("s4_addr", 64'(addr_o), 64'h8000_0300);
      end
`else
      if (n == 100) begin
        check("s4_no_timeout", 64'(timeout), 64'h0);
        check("s4_fen_on", 64'(fen), 64'hffff);
      end
`endif
      @(negedge clk);
    end
`ifdef MEMPOOL_BOOT_CTRL_WATCHDOG_EN
    accept(32'h8000_0400);
    check("s4_restart_to", 64'(timeout), 64'h0);
    @(negedge clk);
    check("s4_restart_fen", 64'(fen), 64'h0001);
`endif
    busy = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single core, unit stagger
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n <= 35; n++) begin
      busy1[0] = (n >= 4 && n < 24);
      if (n == 0) check("n1_fen_t0", 64'(fen1), 64'h0);
      if (n == 1) begin
        check("n1_fen_t1", 64'(fen1), 64'h1);
        check("n1_running", 64'(running1), 64'h1);
      end
      if (n == 31) check("n1_done_early", 64'(done1), 64'h0);
      if (n == 32) begin
        check("n1_done", 64'(done1), 64'h1);
        check("n1_fen_clr", 64'(fen1), 64'h0);
        check("n1_timeout", 64'(timeout1), 64'h0);
        check("n1_addr", 64'(addr1_o), 64'h0000_1000);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
